// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding, master indices and default watchdog limit for the wishbone arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, ABORT = 2'd3} state_e;
  localparam logic MST_MMU = 1'b0;
  localparam logic MST_DMA = 1'b1;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/wb_master_arb_if.sv
// wb_master_arb_if: one wishbone master channel; err only travels back toward a master
interface wb_master_arb_if #(parameter int DW = 32, parameter int AW = 32);
  logic cyc;
  logic we;
  logic [3:0] strb;
  logic [AW-1:0] addr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic ack;
  logic err;
  modport master (output cyc, we, strb, addr, dat_w, input ack, dat_r);
  modport slave (input cyc, we, strb, addr, dat_w, output ack, err, dat_r);
endinterface

// File: rtl/wb_arb_rr_pick.sv
// wb_arb_rr_pick: two-way round-robin picker, favours the requester that was not granted last
module wb_arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick,
  output logic       valid
);
  always_comb begin
    pick[0] = req[0] & (~req[1] | last);
    pick[1] = req[1] & (~req[0] | ~last);
    valid = |req;
  end
endmodule

// File: rtl/wb_master_arb.sv
// wb_master_arb: round-robin arbiter of MMU (m0) and DMA (m1) onto one downstream wishbone channel,
// one transaction per grant, with a watchdog that aborts transfers the slave never acks
module wb_master_arb
  import wb_arb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  wb_master_arb_if.slave  m0,
  wb_master_arb_if.slave  m1,
  wb_master_arb_if.master s,
  output logic [1:0] gnt,
  output logic tout_evt
);
  state_e state_q, state_d;
  logic last_q, last_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [1:0] pick;
  logic valid, act, sel, cyc, done, tmo;
  logic [AW-1:0] addr_mx;
  logic [DW-1:0] wdat_mx;
  wb_arb_rr_pick u_pick (.req({m1.cyc, m0.cyc}), .last(last_q), .pick(pick), .valid(valid));
  always_comb begin
    gnt = {state_q == GNT1, state_q == GNT0};
    act = |gnt;
    sel = gnt[1] ? MST_DMA : MST_MMU;
    cyc = sel ? m1.cyc : m0.cyc;
    addr_mx = sel ? m1.addr : m0.addr;
    wdat_mx = sel ? m1.dat_w : m0.dat_w;
    done = act & cyc & s.ack;
    // an ack landing on the last allowed cycle still completes normally
    tmo = act & cyc & ~s.ack & (tcnt_q == 8'(TIMEOUT - 1));
    tout_evt = tmo;
    s.cyc = act & cyc;
    s.we = act & (sel ? m1.we : m0.we);
    s.strb = act ? (sel ? m1.strb : m0.strb) : '0;
    s.addr = act ? addr_mx : '0;
    s.dat_w = act ? wdat_mx : '0;
    m0.ack = gnt[0] & (done | tmo);
    m1.ack = gnt[1] & (done | tmo);
    m0.err = gnt[0] & tmo;
    m1.err = gnt[1] & tmo;
    m0.dat_r = (gnt[0] & ~tmo) ? s.dat_r : '0;
    m1.dat_r = (gnt[1] & ~tmo) ? s.dat_r : '0;
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    tcnt_d = '0;
    if (state_q == IDLE) begin
      state_d = valid ? (pick[1] ? GNT1 : GNT0) : IDLE;
    end else if (act) begin
      state_d = (done | ~cyc) ? IDLE : (tmo ? ABORT : state_q);
      last_d = (done | ~cyc | tmo) ? sel : last_q;
      tcnt_d = (done | ~cyc | tmo) ? '0 : tcnt_q + 8'd1;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= MST_DMA;
      tcnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      tcnt_q <= tcnt_d;
    end
  end
endmodule

// File: tb/tb_wb_master_arb.sv
// tb_wb_master_arb: directed checks of grant latency, round-robin fairness, watchdog abort and reset
module tb_wb_master_arb;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] gnt;
  logic tout_evt;
  int errors = 0;
  int checks = 0;
  wb_master_arb_if #(.DW(32), .AW(32)) m0_bus ();
  wb_master_arb_if #(.DW(32), .AW(32)) m1_bus ();
  wb_master_arb_if #(.DW(32), .AW(32)) s_bus ();
  assign s_bus.err = 1'b0;
  wb_master_arb #(.DW(32), .AW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus), .gnt(gnt), .tout_evt(tout_evt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [1:0] eg;
    rst = 1'b1;
    {m0_bus.cyc, m0_bus.we, m0_bus.strb, m0_bus.addr, m0_bus.dat_w} = '0;
    {m1_bus.cyc, m1_bus.we, m1_bus.strb, m1_bus.addr, m1_bus.dat_w} = '0;
    s_bus.ack = 1'b0;
    s_bus.dat_r = 32'h0;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_scyc", s_bus.cyc, 1'b0);
    chk("rst_sbus", {s_bus.we, s_bus.strb, s_bus.addr, s_bus.dat_w}, '0);
    chk("rst_mout", {m0_bus.ack, m0_bus.err, m0_bus.dat_r, m1_bus.ack, m1_bus.err}, '0);
    chk("rst_tout", tout_evt, 1'b0);
    tick();
    rst = 1'b0;
    // m0 single read
    m0_bus.cyc = 1'b1; m0_bus.addr = 32'h100; m0_bus.strb = 4'hf;
    smp(); chk("rd_lat", gnt, 2'b00); tick();
    smp(); chk("rd_gnt", gnt, 2'b01); chk("rd_scyc", s_bus.cyc, 1'b1);
    chk("rd_addr", s_bus.addr, 32'h100); chk("rd_strb", s_bus.strb, 4'hf); tick();
    smp(); chk("rd_noack", m0_bus.ack, 1'b0); tick();
    s_bus.ack = 1'b1; s_bus.dat_r = 32'h1234_5678;
    smp(); chk("rd_ack", m0_bus.ack, 1'b1); chk("rd_data", m0_bus.dat_r, 32'h1234_5678);
    chk("rd_err", m0_bus.err, 1'b0); chk("rd_m1ack", m1_bus.ack, 1'b0); chk("rd_m1data", m1_bus.dat_r, 32'h0); tick();
    m0_bus.cyc = 1'b0; s_bus.ack = 1'b0;
    smp(); chk("rd_idle", gnt, 2'b00); chk("rd_saddr0", s_bus.addr, 32'h0); tick();
    // simultaneous requests straight after reset
    rst = 1'b1; tick(); rst = 1'b0;
    m0_bus.cyc = 1'b1; m1_bus.cyc = 1'b1; m1_bus.we = 1'b1; m1_bus.addr = 32'h200; m1_bus.dat_w = 32'haaaa;
    smp(); tick();
    smp(); chk("tie_gnt", gnt, 2'b01); chk("tie_m1ack", m1_bus.ack, 1'b0); chk("tie_swe", s_bus.we, 1'b0); tick();
    s_bus.ack = 1'b1; s_bus.dat_r = 32'h55;
    smp(); chk("tie_m0ack", m0_bus.ack, 1'b1); chk("tie_m1ack2", m1_bus.ack, 1'b0); chk("tie_m1data", m1_bus.dat_r, 32'h0); tick();
    s_bus.ack = 1'b0;
    smp(); chk("tie_idle", gnt, 2'b00); tick();
    // both hold cyc: grants must alternate starting with m1
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 0) ? 2'b10 : 2'b01;
      smp(); chk("rr_gnt", gnt, eg);
      if (eg == 2'b10) begin
        chk("rr_swe", s_bus.we, 1'b1); chk("rr_sdat", s_bus.dat_w, 32'haaaa);
      end
      tick();
      s_bus.ack = 1'b1; s_bus.dat_r = 32'(k + 7);
      smp(); chk("rr_m0ack", m0_bus.ack, eg[0]); chk("rr_m1ack", m1_bus.ack, eg[1]);
      chk("rr_data", eg[1] ? m1_bus.dat_r : m0_bus.dat_r, 32'(k + 7)); tick();
      s_bus.ack = 1'b0;
      if (k == 3) begin
        m0_bus.cyc = 1'b0; m1_bus.cyc = 1'b0;
      end
      smp(); chk("rr_idle", gnt, 2'b00); tick();
    end
    // watchdog timeout on m1
    m1_bus.cyc = 1'b1; s_bus.dat_r = 32'hdead;
    smp(); tick();
    for (int c = 1; c < 8; c++) begin
      smp(); chk("to_gnt", gnt, 2'b10); chk("to_noack", m1_bus.ack, 1'b0); chk("to_noevt", tout_evt, 1'b0); tick();
    end
    smp(); chk("to_ack", m1_bus.ack, 1'b1); chk("to_err", m1_bus.err, 1'b1);
    chk("to_data", m1_bus.dat_r, 32'h0); chk("to_evt", tout_evt, 1'b1); tick();
    m1_bus.cyc = 1'b0; s_bus.ack = 1'b1;
    smp(); chk("ab_scyc", s_bus.cyc, 1'b0); chk("ab_gnt", gnt, 2'b00);
    chk("ab_late", m1_bus.ack, 1'b0); chk("ab_evt", tout_evt, 1'b0); tick();
    smp(); chk("ab_idle", gnt, 2'b00); chk("ab_late2", m1_bus.ack, 1'b0); tick();
    s_bus.ack = 1'b0;
    // ack coincides with the timeout cycle
    m1_bus.cyc = 1'b1;
    smp(); tick();
    for (int c = 1; c < 8; c++) begin
      smp(); tick();
    end
    s_bus.ack = 1'b1;
    smp(); chk("co_ack", m1_bus.ack, 1'b1); chk("co_err", m1_bus.err, 1'b0);
    chk("co_evt", tout_evt, 1'b0); chk("co_data", m1_bus.dat_r, 32'hdead); tick();
    m1_bus.cyc = 1'b0; s_bus.ack = 1'b0;
    smp(); chk("co_idle", gnt, 2'b00); tick();
    // m0 abandons its transfer
    m0_bus.cyc = 1'b1;
    smp(); tick();
    smp(); chk("abn_gnt", gnt, 2'b01); tick();
    m0_bus.cyc = 1'b0;
    smp(); chk("abn_scyc", s_bus.cyc, 1'b0); chk("abn_noack", m0_bus.ack, 1'b0); tick();
    smp(); chk("abn_idle", gnt, 2'b00); tick();
    // async reset in the middle of an m1 grant, then a tie must go to m0
    m1_bus.cyc = 1'b1;
    smp(); tick();
    smp(); chk("mr_gnt", gnt, 2'b10);
    #2 rst = 1'b1;
    #1 chk("mr_gnt0", gnt, 2'b00); chk("mr_scyc0", s_bus.cyc, 1'b0);
    m0_bus.cyc = 1'b1;
    tick();
    rst = 1'b0;
    smp(); chk("mr_held", gnt, 2'b00); tick();
    smp(); chk("mr_tie", gnt, 2'b01); tick();
    m0_bus.cyc = 1'b0; m1_bus.cyc = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
